// File: rtl/tb_irq_stim_gen.sv
// Multi-channel interrupt stimulus generator: off / level-until-ack / fixed pulse / LFSR interval per channel.
// All outputs registered, one cycle after the causing edge; there is no backpressure, cfg writes always take effect.
module tb_irq_stim_gen #(
   parameter int          NUM_CH    = 8,
   parameter int          CNT_W     = 16,
   parameter int          PULSE_LEN = 4,
   parameter logic [15:0] SEED      = 16'hACE1,
   parameter logic [15:0] LFSR_POLY = 16'hB400,
   localparam int         CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              tb_clk,
   input  logic              tb_rst,
   input  logic              cfg_we,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [1:0]        cfg_mode,
   input  logic [CNT_W-1:0]  cfg_period,
   input  logic [NUM_CH-1:0] irq_ack,
   input  logic              wfi_active,
   input  logic              wfi_force_en,
   output logic [NUM_CH-1:0] irq_out,
   output logic [31:0]       fire_cnt,
   output logic [NUM_CH-1:0] ch_busy
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ASSERT} state_t;

   localparam logic [15:0]    SEED_EFF = (SEED == 16'h0) ? 16'h0001 : SEED;
   localparam logic [CNT_W:0] ONE      = {{CNT_W{1'b0}}, 1'b1};
   localparam logic [CNT_W:0] PULSE    = (CNT_W+1)'(PULSE_LEN);

   state_t           state_q  [NUM_CH];
   state_t           state_d  [NUM_CH];
   logic [CNT_W:0]   cnt_q    [NUM_CH];
   logic [CNT_W:0]   cnt_d    [NUM_CH];
   logic [1:0]       mode_q   [NUM_CH];
   logic [CNT_W-1:0] period_q [NUM_CH];

   logic [15:0]      lfsr_q;
   logic [15:0]      lfsr_nxt;
   logic [CNT_W-1:0] lfsr_ext;
   logic             wfi_d;
   logic             wfi_rise;
   logic [6:0]       n_enter;
   logic [32:0]      fire_sum;

   assign lfsr_nxt = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_POLY : 16'h0000);
   assign wfi_rise = wfi_active & ~wfi_d & wfi_force_en;
   assign fire_sum = {1'b0, fire_cnt} + {26'd0, n_enter};

   if (CNT_W > 16) begin : g_lfsr_ext
      assign lfsr_ext = {{(CNT_W-16){1'b0}}, lfsr_q};
   end else begin : g_lfsr_trunc
      assign lfsr_ext = lfsr_q[CNT_W-1:0];
   end

   // Counter is one bit wider than the period so an all-ones random reload cannot wrap to zero.
   function automatic logic [CNT_W:0] reload(input logic [1:0] m, input logic [CNT_W-1:0] p,
                                             input logic [CNT_W-1:0] l);
      logic [CNT_W:0] r;
      if (m == 2'd3)
         r = {1'b0, l & p} + ONE;
      else if (p == '0)
         r = ONE;
      else
         r = {1'b0, p};
      return r;
   endfunction

   always_comb begin
      n_enter = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         state_d[c] = state_q[c];
         cnt_d[c]   = cnt_q[c];
         if (cfg_we && cfg_ch == CH_W'(c)) begin
            if (cfg_mode == 2'd0) begin
               state_d[c] = S_IDLE;
               cnt_d[c]   = '0;
            end else begin
               state_d[c] = S_WAIT;
               cnt_d[c]   = reload(cfg_mode, cfg_period, lfsr_ext);
            end
         end else begin
            case (state_q[c])
               S_WAIT: begin
                  if (wfi_rise || cnt_q[c] == ONE) begin
                     state_d[c] = S_ASSERT;
                     cnt_d[c]   = PULSE;
                  end else begin
                     cnt_d[c] = cnt_q[c] - ONE;
                  end
               end
               S_ASSERT: begin
                  if (mode_q[c] == 2'd2) begin
                     if (cnt_q[c] <= ONE) begin
                        state_d[c] = S_WAIT;
                        cnt_d[c]   = reload(mode_q[c], period_q[c], lfsr_ext);
                     end else begin
                        cnt_d[c] = cnt_q[c] - ONE;
                     end
                  end else if (irq_ack[c]) begin
                     state_d[c] = S_WAIT;
                     cnt_d[c]   = reload(mode_q[c], period_q[c], lfsr_ext);
                  end
               end
               default: ;
            endcase
         end
         if (state_d[c] == S_ASSERT && state_q[c] != S_ASSERT)
            n_enter = n_enter + 7'd1;
      end
   end

   always_ff @(posedge tb_clk) begin
      if (tb_rst) begin
         lfsr_q   <= SEED_EFF;
         wfi_d    <= 1'b0;
         fire_cnt <= '0;
         irq_out  <= '0;
         ch_busy  <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            state_q[c]  <= S_IDLE;
            cnt_q[c]    <= '0;
            mode_q[c]   <= '0;
            period_q[c] <= '0;
         end
      end else begin
         lfsr_q   <= lfsr_nxt;
         wfi_d    <= wfi_active;
         fire_cnt <= fire_sum[32] ? 32'hFFFF_FFFF : fire_sum[31:0];
         for (int c = 0; c < NUM_CH; c++) begin
            state_q[c] <= state_d[c];
            cnt_q[c]   <= cnt_d[c];
            irq_out[c] <= (state_d[c] == S_ASSERT);
            ch_busy[c] <= (state_d[c] != S_IDLE);
            if (cfg_we && cfg_ch == CH_W'(c)) begin
               mode_q[c]   <= cfg_mode;
               period_q[c] <= cfg_period;
            end
         end
      end
   end

endmodule

// File: tb/tb_tb_irq_stim_gen.sv
// Directed bench for tb_irq_stim_gen: six channels so that cfg_ch values 6 and 7 are out of range.
module tb_tb_irq_stim_gen;

   logic        tb_clk = 1'b0;
   logic        tb_rst = 1'b1;
   logic        cfg_we = 1'b0;
   logic [2:0]  cfg_ch = '0;
   logic [1:0]  cfg_mode = '0;
   logic [15:0] cfg_period = '0;
   logic [5:0]  irq_ack = '0;
   logic        wfi_active = 1'b0;
   logic        wfi_force_en = 1'b0;
   logic [5:0]  irq_out;
   logic [31:0] fire_cnt;
   logic [5:0]  ch_busy;

   int checks = 0;
   int passed = 0;
   logic [15:0] m_lfsr;

   tb_irq_stim_gen #(.NUM_CH(6), .CNT_W(16), .PULSE_LEN(4), .SEED(16'hACE1), .LFSR_POLY(16'hB400)) dut (
      .tb_clk(tb_clk), .tb_rst(tb_rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
      .cfg_period(cfg_period), .irq_ack(irq_ack), .wfi_active(wfi_active), .wfi_force_en(wfi_force_en),
      .irq_out(irq_out), .fire_cnt(fire_cnt), .ch_busy(ch_busy)
   );

   always #5 tb_clk = ~tb_clk;

   // Reference Galois LFSR, seen at negedge it holds the value the DUT uses in that cycle
   always @(posedge tb_clk) begin
      if (tb_rst) m_lfsr <= 16'hACE1;
      else        m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
   end

   task automatic cfg_write(input logic [2:0] ch, input logic [1:0] mode, input logic [15:0] per);
      cfg_we = 1'b1; cfg_ch = ch; cfg_mode = mode; cfg_period = per;
      @(negedge tb_clk);
      cfg_we = 1'b0;
   endtask

   task automatic do_reset();
      irq_ack = '0; wfi_active = 1'b0; wfi_force_en = 1'b0; cfg_we = 1'b0;
      tb_rst = 1'b1;
      repeat (3) @(negedge tb_clk);
      tb_rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (irq_out !== 6'b0) $display("FAIL reset_irq got=%b exp=000000", irq_out); else passed++;
      checks++; if (ch_busy !== 6'b0) $display("FAIL reset_busy got=%b exp=000000", ch_busy); else passed++;
      checks++; if (fire_cnt !== 32'd0) $display("FAIL reset_fire got=%0d exp=0", fire_cnt); else passed++;
   endtask

   // Must run in the first cycle after reset release: LFSR=ACE1, so first gap = (ACE1&F)+1 = 2
   task automatic test_random();
      int gap;
      int r_exp;
      irq_ack = 6'b000010;
      r_exp = 2;
      cfg_write(3'd1, 2'd3, 16'h000F);
      for (int i = 0; i < 7; i++) begin
         gap = 0;
         while (irq_out[1] == 1'b0 && gap < 40) begin
            gap++;
            @(negedge tb_clk);
         end
         checks++; if (gap !== r_exp) $display("FAIL random_gap%0d got=%0d exp=%0d", i, gap, r_exp); else passed++;
         checks++; if (gap < 1 || gap > 16) $display("FAIL random_range%0d got=%0d exp=1..16", i, gap); else passed++;
         r_exp = int'(m_lfsr & 16'h000F) + 1;
         @(negedge tb_clk);
      end
      cfg_write(3'd1, 2'd3, 16'h0000);
      for (int i = 0; i < 3; i++) begin
         gap = 0;
         while (irq_out[1] == 1'b0 && gap < 40) begin
            gap++;
            @(negedge tb_clk);
         end
         checks++; if (gap !== 1) $display("FAIL random_p0_gap%0d got=%0d exp=1", i, gap); else passed++;
         @(negedge tb_clk);
      end
      irq_ack = '0;
   endtask

   task automatic test_level();
      do_reset();
      cfg_write(3'd0, 2'd1, 16'd5);
      for (int k = 1; k <= 5; k++) begin
         checks++; if (irq_out[0] !== 1'b0) $display("FAIL level_low t+%0d got=%b exp=0", k, irq_out[0]); else passed++;
         @(negedge tb_clk);
      end
      for (int k = 6; k <= 10; k++) begin
         checks++; if (irq_out[0] !== 1'b1) $display("FAIL level_high t+%0d got=%b exp=1", k, irq_out[0]); else passed++;
         if (k < 10) @(negedge tb_clk);
      end
      irq_ack[0] = 1'b1;
      @(negedge tb_clk);
      irq_ack[0] = 1'b0;
      for (int k = 11; k <= 15; k++) begin
         checks++; if (irq_out[0] !== 1'b0) $display("FAIL level_gap t+%0d got=%b exp=0", k, irq_out[0]); else passed++;
         @(negedge tb_clk);
      end
      checks++; if (irq_out[0] !== 1'b1) $display("FAIL level_rearm got=%b exp=1", irq_out[0]); else passed++;
      checks++; if (fire_cnt !== 32'd2) $display("FAIL level_fire got=%0d exp=2", fire_cnt); else passed++;
   endtask

   task automatic test_pulse();
      logic e;
      do_reset();
      irq_ack = 6'b001000;
      cfg_write(3'd3, 2'd2, 16'd0);
      for (int k = 1; k <= 12; k++) begin
         e = (k >= 2) && (((k - 2) % 5) < 4);
         checks++; if (irq_out[3] !== e) $display("FAIL pulse t+%0d got=%b exp=%b", k, irq_out[3], e); else passed++;
         @(negedge tb_clk);
      end
      checks++; if (fire_cnt !== 32'd3) $display("FAIL pulse_fire got=%0d exp=3", fire_cnt); else passed++;
      irq_ack = '0;
   endtask

   task automatic test_wfi();
      do_reset();
      cfg_write(3'd0, 2'd1, 16'd1000);
      cfg_write(3'd2, 2'd1, 16'd1000);
      repeat (3) @(negedge tb_clk);
      checks++; if (ch_busy !== 6'b000101) $display("FAIL wfi_busy got=%b exp=000101", ch_busy); else passed++;
      wfi_force_en = 1'b1;
      wfi_active = 1'b1;
      @(negedge tb_clk);
      checks++; if (irq_out !== 6'b000101) $display("FAIL wfi_force got=%b exp=000101", irq_out); else passed++;
      checks++; if (fire_cnt !== 32'd2) $display("FAIL wfi_fire got=%0d exp=2", fire_cnt); else passed++;
      irq_ack = 6'b000101;
      @(negedge tb_clk);
      irq_ack = '0;
      checks++; if (irq_out !== 6'b0) $display("FAIL wfi_ack got=%b exp=000000", irq_out); else passed++;
      repeat (10) @(negedge tb_clk);
      checks++; if (irq_out !== 6'b0) $display("FAIL wfi_level_hold got=%b exp=000000", irq_out); else passed++;
      checks++; if (fire_cnt !== 32'd2) $display("FAIL wfi_no_retrig got=%0d exp=2", fire_cnt); else passed++;
      wfi_active = 1'b0;
      wfi_force_en = 1'b0;
   endtask

   task automatic test_conflict();
      do_reset();
      cfg_write(3'd0, 2'd1, 16'd0);
      @(negedge tb_clk);
      checks++; if (irq_out[0] !== 1'b1) $display("FAIL conf_assert got=%b exp=1", irq_out[0]); else passed++;
      irq_ack[0] = 1'b1;
      cfg_write(3'd0, 2'd0, 16'd0);
      irq_ack[0] = 1'b0;
      checks++; if (irq_out[0] !== 1'b0) $display("FAIL conf_drop got=%b exp=0", irq_out[0]); else passed++;
      checks++; if (ch_busy[0] !== 1'b0) $display("FAIL conf_idle got=%b exp=0", ch_busy[0]); else passed++;
      repeat (5) @(negedge tb_clk);
      checks++; if (ch_busy !== 6'b0) $display("FAIL conf_noreload got=%b exp=000000", ch_busy); else passed++;
      checks++; if (fire_cnt !== 32'd1) $display("FAIL conf_fire got=%0d exp=1", fire_cnt); else passed++;
      cfg_write(3'd7, 2'd1, 16'd0);
      repeat (4) @(negedge tb_clk);
      checks++; if (ch_busy !== 6'b0) $display("FAIL oor_busy got=%b exp=000000", ch_busy); else passed++;
      checks++; if (irq_out !== 6'b0) $display("FAIL oor_irq got=%b exp=000000", irq_out); else passed++;
      cfg_write(3'd2, 2'd1, 16'd100);
      repeat (3) @(negedge tb_clk);
      checks++; if (ch_busy !== 6'b000100) $display("FAIL midrst_pre got=%b exp=000100", ch_busy); else passed++;
      tb_rst = 1'b1;
      @(negedge tb_clk);
      tb_rst = 1'b0;
      checks++; if (ch_busy !== 6'b0) $display("FAIL midrst_busy got=%b exp=000000", ch_busy); else passed++;
      checks++; if (fire_cnt !== 32'd0) $display("FAIL midrst_fire got=%0d exp=0", fire_cnt); else passed++;
      repeat (110) @(negedge tb_clk);
      checks++; if (irq_out !== 6'b0) $display("FAIL midrst_cleared got=%b exp=000000", irq_out); else passed++;
      checks++; if (ch_busy !== 6'b0) $display("FAIL midrst_idle got=%b exp=000000", ch_busy); else passed++;
   endtask

   initial begin
      @(negedge tb_clk);
      test_reset();
      test_random();
      test_level();
      test_pulse();
      test_wfi();
      test_conflict();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
